// File: rtl/nand_bist_ctrl.sv
// Built-in self-test sequencer for one NAND gate. Walks {in0,in1} through
// 00, 01, 10, 11 for PASSES sweeps, holds each vector SETTLE_CYCLES cycles,
// then compares the gate output against the NAND truth table. Mismatches are
// counted (saturating), flagged per vector, and summarised in pass/done.
//
// Handshake: start and abort are level-sampled requests with no ready side.
// start is honoured only in IDLE or DONE. abort wins over start in every
// state. done is a status level, held until start, abort or reset.
module nand_bist_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int PASSES        = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic       drive_in0,
  output logic       drive_in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       err_pulse,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

  state_t     state_q, state_d;
  logic [1:0] vec_q, vec_d;
  logic [7:0] pass_cnt_q, pass_cnt_d;
  logic [7:0] settle_q, settle_d;
  logic [1:0] drv_q, drv_d;
  logic       pass_q, pass_d;
  logic       err_pulse_q, err_pulse_d;
  logic [7:0] err_count_q, err_count_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  logic       exp_bit;
  logic       mismatch;
  logic       last_vec;

  // NAND truth table: only vector 3 (11) produces a 0.
  assign exp_bit  = ~(vec_q[1] & vec_q[0]);
  assign mismatch = (dut_out != exp_bit);
  assign last_vec = (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);

  // State and datapath registers; reset forces every output to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      vec_q       <= 2'd0;
      pass_cnt_q  <= 8'd0;
      settle_q    <= 8'd0;
      drv_q       <= 2'b00;
      pass_q      <= 1'b0;
      err_pulse_q <= 1'b0;
      err_count_q <= 8'd0;
      fail_vec_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      pass_cnt_q  <= pass_cnt_d;
      settle_q    <= settle_d;
      drv_q       <= drv_d;
      pass_q      <= pass_d;
      err_pulse_q <= err_pulse_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  // Next-state and datapath update; err_pulse defaults low so it is one cycle.
  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    pass_cnt_d  = pass_cnt_q;
    settle_d    = settle_q;
    drv_d       = drv_q;
    pass_d      = pass_q;
    err_pulse_d = 1'b0;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
          drv_d   = 2'b00;
        end else if (start) begin
          err_count_d = 8'd0;
          fail_vec_d  = 4'd0;
          pass_d      = 1'b0;
          vec_d       = 2'd0;
          drv_d       = 2'b00;
          pass_cnt_d  = 8'd0;
          settle_d    = SETTLE_LOAD;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_d = IDLE;
          drv_d   = 2'b00;
          pass_d  = 1'b0;
        end else if (settle_q == 8'd0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      CHECK: begin
        if (abort) begin
          // The comparison pending in this cycle is dropped.
          state_d = IDLE;
          drv_d   = 2'b00;
          pass_d  = 1'b0;
        end else begin
          if (mismatch) begin
            err_pulse_d = 1'b1;
            err_count_d = (err_count_q == 8'hFF) ? 8'hFF : err_count_q + 8'd1;
            fail_vec_d  = fail_vec_q | (4'b0001 << vec_q);
          end
          if (last_vec) begin
            state_d = DONE;
            drv_d   = 2'b00;
            pass_d  = (err_count_d == 8'd0);
          end else begin
            vec_d    = vec_q + 2'd1;
            drv_d    = vec_q + 2'd1;
            settle_d = SETTLE_LOAD;
            state_d  = SETTLE;
            if (vec_q == 2'd3) pass_cnt_d = pass_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign drive_in0 = drv_q[1];
  assign drive_in1 = drv_q[0];
  assign busy      = (state_q == SETTLE) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = pass_q;
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nand_bist_ctrl.sv
// Directed bench for nand_bist_ctrl. Three instances: A (defaults, gate model
// selectable), B (SETTLE_CYCLES=1, PASSES=2, AND gate), C (SETTLE_CYCLES=1,
// PASSES=86, output stuck at 0). Inputs change and outputs are sampled on the
// falling clock edge.
module tb_nand_bist_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];

  // 0 = good NAND, 1 = stuck at 1, 2 = stuck at 0, 3 = AND
  int gate_mode = 0;

  // ---------------- instance A ----------------
  logic       start_a, abort_a, dut_out_a, d0_a, d1_a, busy_a, done_a, pass_a, errp_a;
  logic [7:0] errc_a;
  logic [3:0] fv_a;
  logic [1:0] st_a;

  // Gate under test model for instance A.
  always_comb begin
    dut_out_a = 1'b0;
    case (gate_mode)
      0:       dut_out_a = ~(d0_a & d1_a);
      1:       dut_out_a = 1'b1;
      2:       dut_out_a = 1'b0;
      default: dut_out_a = d0_a & d1_a;
    endcase
  end

  nand_bist_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .dut_out(dut_out_a),
    .drive_in0(d0_a), .drive_in1(d1_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_pulse(errp_a), .err_count(errc_a), .fail_vec(fv_a), .dbg_state(st_a)
  );

  // ---------------- instance B ----------------
  logic       start_b, abort_b, dut_out_b, d0_b, d1_b, busy_b, done_b, pass_b, errp_b;
  logic [7:0] errc_b;
  logic [3:0] fv_b;
  logic [1:0] st_b;
  assign dut_out_b = d0_b & d1_b;

  nand_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(dut_out_b),
    .drive_in0(d0_b), .drive_in1(d1_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_pulse(errp_b), .err_count(errc_b), .fail_vec(fv_b), .dbg_state(st_b)
  );

  // ---------------- instance C ----------------
  logic       start_c, abort_c, dut_out_c, d0_c, d1_c, busy_c, done_c, pass_c, errp_c;
  logic [7:0] errc_c;
  logic [3:0] fv_c;
  logic [1:0] st_c;
  assign dut_out_c = 1'b0;

  nand_bist_ctrl #(.SETTLE_CYCLES(1), .PASSES(86)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .dut_out(dut_out_c),
    .drive_in0(d0_c), .drive_in1(d1_c), .busy(busy_c), .done(done_c), .pass(pass_c),
    .err_pulse(errp_c), .err_count(errc_c), .fail_vec(fv_c), .dbg_state(st_c)
  );

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one full run on instance A ----------------
  // Called at a falling edge. Expected driver vectors (5 edges each) and the
  // final {pass, err_count, fail_vec} go into the scoreboard up front.
  task automatic run_a(input int mode, input logic pass_e, input logic [7:0] cnt_e,
                       input logic [3:0] fv_e, input logic pulse20_e, input int npulse_e);
    int npulse;
    npulse = 0;
    gate_mode = mode;
    for (int i = 0; i < 20; i++) exp_q.push_back(13'(i / 5));
    exp_q.push_back({pass_e, cnt_e, fv_e});
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) begin
        @(negedge clk);
        npulse += int'(errp_a);
      end
      chk($sformatf("a_drv_e%0d", k), 32'({d0_a, d1_a}), 32'(exp_q.pop_front()));
    end
    chk("a_busy_e19", 32'(busy_a), 32'd1);
    chk("a_done_e19", 32'(done_a), 32'd0);
    @(negedge clk);
    npulse += int'(errp_a);
    chk("a_done_e20", 32'(done_a), 32'd1);
    chk("a_pulse_e20", 32'(errp_a), 32'(pulse20_e));
    chk("a_drv_done", 32'({d0_a, d1_a}), 32'd0);
    chk("a_result", 32'({pass_a, errc_a, fv_a}), 32'(exp_q.pop_front()));
    chk("a_npulse", 32'(npulse), 32'(npulse_e));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0;
    start_b = 1'b0; abort_b = 1'b0;
    start_c = 1'b0; abort_c = 1'b0;
    #1;
    chk("rst_outputs", 32'({d0_a, d1_a, busy_a, done_a, pass_a, errp_a, errc_a, fv_a}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_state", 32'(st_a), 32'd0);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // Good gate, defaults.
    run_a(0, 1'b1, 8'd0, 4'b0000, 1'b0, 0);
    @(negedge clk);
    chk("done_held", 32'(done_a), 32'd1);

    // Output stuck at 1: only vector 3 fails, pulse after edge 20.
    run_a(1, 1'b0, 8'd1, 4'b1000, 1'b1, 1);

    // Abort together with start during the third vector's SETTLE (AND gate).
    gate_mode = 3;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (11) @(negedge clk);
    chk("abort_pre_drv", 32'({d0_a, d1_a}), 32'b10);
    chk("abort_pre_st", 32'(st_a), 32'd1);
    abort_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    chk("abort_drv", 32'({d0_a, d1_a}), 32'd0);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    chk("abort_pass", 32'(pass_a), 32'd0);
    chk("abort_keep", 32'({errc_a, fv_a}), 32'({8'd2, 4'b0011}));
    @(negedge clk);
    chk("abort_prio", 32'(busy_a), 32'd0);
    abort_a = 1'b0;
    start_a = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(st_a), 32'd0);
    run_a(0, 1'b1, 8'd0, 4'b0000, 1'b0, 0);

    // Instance B: AND gate, two passes, one settle cycle.
    exp_q.push_back({1'b0, 8'd8, 4'b1111});
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (15) @(negedge clk);
    chk("b_done_e15", 32'(done_b), 32'd0);
    @(negedge clk);
    chk("b_done_e16", 32'(done_b), 32'd1);
    chk("b_result", 32'({pass_b, errc_b, fv_b}), 32'(exp_q.pop_front()));

    // Back-to-back: start held through DONE restarts and done lasts one cycle.
    start_b = 1'b1;
    @(negedge clk);
    chk("b2b_restart", 32'({busy_b, done_b, errc_b}), 32'({1'b1, 1'b0, 8'd0}));
    repeat (15) @(negedge clk);
    chk("b2b_done_e15", 32'(done_b), 32'd0);
    @(negedge clk);
    chk("b2b_done_e16", 32'({done_b, errc_b}), 32'({1'b1, 8'd8}));
    @(negedge clk);
    chk("b2b_done_1cyc", 32'({done_b, busy_b, errc_b}), 32'({1'b0, 1'b1, 8'd0}));
    start_b = 1'b0;
    abort_b = 1'b1;
    @(negedge clk);
    chk("b_abort", 32'(busy_b), 32'd0);
    abort_b = 1'b0;

    // Instance C: stuck at 0, 86 passes -> 258 mismatches saturate at 255.
    exp_q.push_back({1'b0, 8'd255, 4'b0111});
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    n = 0;
    while (!done_c && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("c_latency", 32'(n), 32'd688);
    chk("c_result", 32'({pass_c, errc_c, fv_c}), 32'(exp_q.pop_front()));

    // Reset in CHECK of vector 3 with a stuck-at-1 mismatch pending.
    gate_mode = 1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (19) @(negedge clk);
    chk("rst_pre_st", 32'(st_a), 32'd2);
    chk("rst_pre_drv", 32'({d0_a, d1_a}), 32'b11);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'({d0_a, d1_a, busy_a, done_a, pass_a, errp_a, errc_a, fv_a}), 32'd0);
    @(negedge clk);
    chk("rst_no_pulse", 32'(errp_a), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_idle", 32'({st_a, busy_a, errp_a, errc_a}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
